// File: rtl/eth_rx_frame_sink.sv
// eth_rx_frame_sink: two-slot ping-pong frame buffer fed by an 8-bit AXI-stream RX MAC output
module eth_rx_frame_sink #(
    parameter int BUF_ADDR_WIDTH = 11
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [7:0]                s_axis_tdata,
    input  logic                      s_axis_tvalid,
    input  logic                      s_axis_tlast,
    input  logic                      s_axis_tuser,
    output logic                      frm_avail,
    output logic                      frm_slot,
    output logic [BUF_ADDR_WIDTH:0]   frm_len,
    input  logic                      frm_release,
    input  logic                      rd_slot,
    input  logic [BUF_ADDR_WIDTH-3:0] rd_addr,
    output logic [31:0]               rd_data,
    output logic [15:0]               cnt_good,
    output logic [15:0]               cnt_err,
    output logic [15:0]               cnt_drop,
    output logic [15:0]               cnt_oversize
);
    localparam int AW = BUF_ADDR_WIDTH;
    typedef enum logic [1:0] {IDLE, RECV, DISCARD} state_t;
    state_t state, nstate;
    logic [AW:0] count, ncount;
    logic [AW:0] len [2];
    logic [1:0] full;
    logic wp, hp, reason_ovs, nreason_ovs;
    logic we, fin, inc_drop, inc_ovs, commit, inc_err, rel;
    logic [AW-1:0] off;
    logic [31:0] mem [2**(AW-1)];
    assign commit = fin && !s_axis_tuser;
    assign inc_err = fin && s_axis_tuser;
    assign rel = frm_release && full[hp];
    assign frm_avail = full[hp];
    assign frm_slot = hp;
    assign frm_len = len[hp];
    // next-state, byte write and finalize decisions for the incoming beat
    always_comb begin
        nstate = state;
        ncount = count;
        nreason_ovs = reason_ovs;
        we = 1'b0;
        off = count[AW-1:0];
        fin = 1'b0;
        inc_drop = 1'b0;
        inc_ovs = 1'b0;
        if (s_axis_tvalid) begin
            case (state)
                IDLE: begin
                    if (!full[wp]) begin
                        we = 1'b1;
                        off = '0;
                        ncount = (AW+1)'(1);
                        fin = s_axis_tlast;
                        nstate = s_axis_tlast ? IDLE : RECV;
                    end else begin
                        inc_drop = s_axis_tlast;
                        nreason_ovs = 1'b0;
                        nstate = s_axis_tlast ? IDLE : DISCARD;
                    end
                end
                RECV: begin
                    if (count[AW]) begin
                        inc_ovs = s_axis_tlast;
                        nreason_ovs = 1'b1;
                        nstate = s_axis_tlast ? IDLE : DISCARD;
                    end else begin
                        we = 1'b1;
                        ncount = count + 1'b1;
                        fin = s_axis_tlast;
                        nstate = s_axis_tlast ? IDLE : RECV;
                    end
                end
                default: begin
                    inc_drop = s_axis_tlast && !reason_ovs;
                    inc_ovs = s_axis_tlast && reason_ovs;
                    nstate = s_axis_tlast ? IDLE : DISCARD;
                end
            endcase
        end
    end
    // FSM, slot bookkeeping and saturating counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
            reason_ovs <= 1'b0;
            full <= '0;
            wp <= 1'b0;
            hp <= 1'b0;
            len[0] <= '0;
            len[1] <= '0;
            cnt_good <= '0;
            cnt_err <= '0;
            cnt_drop <= '0;
            cnt_oversize <= '0;
        end else begin
            state <= nstate;
            count <= ncount;
            reason_ovs <= nreason_ovs;
            if (rel) begin
                full[hp] <= 1'b0;
                hp <= ~hp;
            end
            if (commit) begin
                full[wp] <= 1'b1;
                len[wp] <= ncount;
                wp <= ~wp;
            end
            cnt_good <= cnt_good + 16'(commit && cnt_good != 16'hFFFF);
            cnt_err <= cnt_err + 16'(inc_err && cnt_err != 16'hFFFF);
            cnt_drop <= cnt_drop + 16'(inc_drop && cnt_drop != 16'hFFFF);
            cnt_oversize <= cnt_oversize + 16'(inc_ovs && cnt_oversize != 16'hFFFF);
        end
    end
    // byte-lane writes into the shared word RAM
    always_ff @(posedge clk) begin
        if (we) mem[{wp, off[AW-1:2]}][{off[1:0], 3'b000} +: 8] <= s_axis_tdata;
    end
    // registered word read port
    always_ff @(posedge clk) begin
        if (!rst_n) rd_data <= '0;
        else rd_data <= mem[{rd_slot, rd_addr}];
    end
endmodule
